// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared ring-router output-port definitions: input port indices, the reset
// priority value and the one-hot to binary select encoder.
package plab4_net_router_output_ctrl_pkg;

    localparam logic [1:0] PORT_WEST = 2'd0;
    localparam logic [1:0] PORT_TERM = 2'd1;
    localparam logic [1:0] PORT_EAST = 2'd2;

    localparam logic [2:0] PRIO_RESET = 3'b001;

    // Zero input maps to west so an idle port still presents a legal mux select.
    function automatic logic [1:0] onehot_enc(input logic [2:0] oh);
        logic [1:0] enc;
        enc = PORT_WEST;
        if (oh[2])
            enc = PORT_EAST;
        else if (oh[1])
            enc = PORT_TERM;
        return enc;
    endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_arb.sv
// Combinational round-robin pick: first request at or above the one-hot
// priority bit, wrapping from east back to west. Zero latency, no state.
module plab4_net_RoundRobinArbComb (
    input  logic [2:0] prio,
    input  logic [2:0] reqs,
    output logic [2:0] win
);

    logic [5:0] w_dbl;
    logic [5:0] w_mask;

    // Doubling the request vector turns the wrap-around scan into a plain
    // "lowest set bit at or above prio" search, isolated by the borrow chain.
    assign w_dbl  = {reqs, reqs};
    assign w_mask = w_dbl & ~(w_dbl - {3'b000, prio});
    assign win    = w_mask[2:0] | w_mask[5:3];

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Per-output-port control: per-domain round-robin arbitration, grants, val and
// crossbar select in the same cycle; out_rdy low zeroes grants and freezes priority.
module plab4_net_router_output_ctrl
    import plab4_net_router_output_ctrl_pkg::*;
#(
    parameter int p_num_reqs    = 3,
    parameter int p_num_domains = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cur_sd,
    input  logic [p_num_reqs-1:0] reqs,
    output logic [p_num_reqs-1:0] grants,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [1:0]            sel
);

    logic [2:0] r_prio [p_num_domains];
    logic [2:0] w_prio;
    logic [2:0] w_win;
    logic       w_xfer;

    assign w_prio = r_prio[cur_sd];

    plab4_net_RoundRobinArbComb u_arb (
        .prio (w_prio),
        .reqs (reqs),
        .win  (w_win)
    );

    // Reset masks the outputs so a request pending across reset is dropped.
    assign out_val = ~reset & (|reqs);
    assign w_xfer  = out_val & out_rdy;
    assign grants  = w_win & {p_num_reqs{w_xfer}};
    assign sel     = reset ? PORT_WEST : onehot_enc(w_win);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < p_num_domains; d++)
                r_prio[d] <= PRIO_RESET;
        end else if (w_xfer) begin
            r_prio[cur_sd] <= {w_win[1:0], w_win[2]};
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Scoreboard bench for the router output control: directed scenarios then random
// traffic, checked against an index-based round-robin model per security domain.
module tb_plab4_net_router_output_ctrl;

    typedef struct packed {
        logic [2:0] g;
        logic       v;
        logic [1:0] s;
    } resp_t;

    logic       clk;
    logic       reset;
    logic       cur_sd;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] sel;

    resp_t q_exp[$];
    int    n_vec;
    int    n_err;
    int    hp [2];   // index of the highest-priority input per domain

    plab4_net_router_output_ctrl #(
        .p_num_reqs    (3),
        .p_num_domains (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cur_sd  (cur_sd),
        .reqs    (reqs),
        .grants  (grants),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, predict the response, then advance the model
    // to the state it will hold after this cycle's edge.
    task automatic apply(input logic rst, input logic sd, input logic [2:0] rq, input logic rdy);
        resp_t e;
        int    w;
        @(posedge clk);
        #1;
        reset   = rst;
        cur_sd  = sd;
        reqs    = rq;
        out_rdy = rdy;
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (hp[sd] + k) % 3;
            if (w < 0 && rq[idx]) w = idx;
        end
        e.v = (!rst && w >= 0);
        e.s = e.v ? 2'(w) : 2'd0;
        e.g = (e.v && rdy) ? 3'(1 << w) : 3'b000;
        q_exp.push_back(e);
        if (rst) begin
            hp[0] = 0;
            hp[1] = 0;
        end else if (e.v && rdy) begin
            hp[sd] = (w + 1) % 3;
        end
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            resp_t e;
            resp_t a;
            e = q_exp.pop_front();
            a = '{g: grants, v: out_val, s: sel};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL vec%0d rst=%0b sd=%0b reqs=%b rdy=%0b: got grants=%b val=%b sel=%0d, want grants=%b val=%b sel=%0d",
                         n_vec, reset, cur_sd, reqs, out_rdy, a.g, a.v, a.s, e.g, e.v, e.s);
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        hp[0]   = 0;
        hp[1]   = 0;
        reset   = 1'b1;
        cur_sd  = 1'b0;
        reqs    = 3'b000;
        out_rdy = 1'b0;

        // Reset state with requests present, then rotation from the reset priority.
        apply(1, 0, 3'b111, 1);
        apply(1, 0, 3'b111, 1);
        repeat (4) apply(0, 0, 3'b111, 1);

        // Backpressure holds grants low and freezes priority.
        repeat (3) apply(0, 0, 3'b110, 0);
        apply(0, 0, 3'b110, 1);

        // Domain isolation.
        apply(1, 0, 3'b000, 0);
        repeat (2) apply(0, 0, 3'b111, 1);
        apply(0, 1, 3'b111, 1);
        apply(0, 0, 3'b111, 1);

        // Single requester, then idle.
        repeat (3) apply(0, 0, 3'b100, 1);
        repeat (2) apply(0, 0, 3'b000, 1);

        // Reset mid-operation with distinct priorities in each domain.
        apply(1, 0, 3'b000, 0);
        apply(0, 0, 3'b111, 1);
        repeat (2) apply(0, 1, 3'b111, 1);
        apply(1, 0, 3'b111, 1);
        apply(0, 0, 3'b111, 1);
        apply(0, 1, 3'b111, 1);

        // Wrap past the east input.
        apply(1, 0, 3'b000, 0);
        repeat (2) apply(0, 0, 3'b111, 1);
        repeat (2) apply(0, 0, 3'b011, 1);

        // Random traffic with occasional resets and frequent domain switches.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        begin
            int budget;
            budget = 20;
            while (q_exp.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q_exp.size() > 0) begin
                n_err++;
                $display("FAIL drain: %0d responses still pending, want 0", q_exp.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
